// File: rtl/game_round_sequencer.sv
// game_round_sequencer: multi-round game scheduler.
// Once access is granted, each round loads a random number, runs the digit
// timer, and then takes either player 2's entry or the timeout. For an entry,
// it waits a fixed latency, samples the verification verdict, and updates a
// saturating score.
// Optional feature macro: SEQ_TIMEOUT_PENALTY_EN. When it is defined, a
// timeout takes one point off the score (saturating at 0).
// Pulse semantics: load_rand and load_p2 are single-cycle strobes, and the
// consumer latches on the cycle they are high. No ready/back-pressure exists.
// timer_run is a level that is high for exactly the cycles spent in RUN.
// All outputs are registered from the next-state decode.
// dbg_state mirrors the FSM state register for observation.
module game_round_sequencer #(
  parameter int NUM_ROUNDS = 4,
  parameter int SCORE_W    = 4,
  parameter int VERIFY_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               access_ok,
  input  logic               start_btn,
  input  logic               p2_btn,
  input  logic               timer_done,
  input  logic               verify_ok,
  output logic               load_rand,
  output logic               load_p2,
  output logic               timer_run,
  output logic [3:0]         round_num,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_over,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    WAIT_V  = 3'd4,
    SCORE   = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [2:0]         LAT_LOAD   = 3'(VERIFY_LAT - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t               state, state_d;
  logic [2:0]           lat_cnt, lat_cnt_d;
  logic                 timed_out, timed_out_d;
  logic                 verdict, verdict_d;
  logic [3:0]           round_d;
  logic [SCORE_W-1:0]   score_d;
  logic                 busy_state;

  assign dbg_state = state;

  // Next-state and next datapath values; abort on lost access overrides all busy states.
  always_comb begin
    state_d     = state;
    lat_cnt_d   = lat_cnt;
    timed_out_d = timed_out;
    verdict_d   = verdict;
    round_d     = round_num;
    score_d     = score;
    busy_state  = (state != IDLE) && (state != DONE);

    if (busy_state && !access_ok) begin
      state_d = IDLE;
      round_d = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_btn && access_ok) begin
            state_d = ARM;
            score_d = '0;
            round_d = 4'd1;
          end
        end
        ARM: begin
          state_d     = RUN;
          timed_out_d = 1'b0;
          verdict_d   = 1'b0;
        end
        RUN: begin
          // Player entry beats a coincident timeout.
          if (p2_btn) begin
            state_d = CAPTURE;
          end else if (timer_done) begin
            state_d     = SCORE;
            timed_out_d = 1'b1;
          end
        end
        CAPTURE: begin
          lat_cnt_d = LAT_LOAD;
          state_d   = WAIT_V;
        end
        WAIT_V: begin
          if (lat_cnt == 3'd0) begin
            verdict_d = verify_ok;
            state_d   = SCORE;
          end else begin
            lat_cnt_d = lat_cnt - 3'd1;
          end
        end
        SCORE: begin
          if (timed_out) begin
`ifdef SEQ_TIMEOUT_PENALTY_EN
            if (score != '0) score_d = score - 1'b1;
`endif
          end else if (verdict && (score != SCORE_MAX)) begin
            score_d = score + 1'b1;
          end
          if (round_num == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_num + 4'd1;
            state_d = ARM;
          end
        end
        DONE: begin
          if (start_btn && access_ok) begin
            state_d = ARM;
            score_d = '0;
            round_d = 4'd1;
          end else if (!access_ok) begin
            state_d = IDLE;
            round_d = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Round datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt   <= 3'd0;
      timed_out <= 1'b0;
      verdict   <= 1'b0;
      round_num <= 4'd0;
      score     <= '0;
      load_rand <= 1'b0;
      load_p2   <= 1'b0;
      timer_run <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      lat_cnt   <= lat_cnt_d;
      timed_out <= timed_out_d;
      verdict   <= verdict_d;
      round_num <= round_d;
      score     <= score_d;
      load_rand <= (state_d == ARM);
      load_p2   <= (state_d == CAPTURE);
      timer_run <= (state_d == RUN);
      busy      <= (state_d != IDLE) && (state_d != DONE);
      game_over <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer. Instance a uses the default parameters.
// Instance b (SCORE_W=2, NUM_ROUNDS=5) covers score saturation.
// The expected {round, score} after each scored round is queued when the round is driven.
// A negedge monitor pops and compares one entry each time a SCORE state completes.
`timescale 1ns/1ps
module tb_game_round_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2,
                         S_WAIT_V = 3'd4, S_SCORE = 3'd5, S_DONE = 3'd6;
  localparam int K_OK = 0, K_FAIL = 1, K_TO = 2, K_SIM = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic access_v[2], start_v[2], p2_v[2], tdone_v[2], vok_v[2];

  logic       a_load_rand, a_load_p2, a_timer_run, a_busy, a_game_over;
  logic [3:0] a_round, a_score;
  logic [2:0] a_state;
  logic       b_load_rand, b_load_p2, b_timer_run, b_busy, b_game_over;
  logic [3:0] b_round;
  logic [1:0] b_score;
  logic [2:0] b_state;

  game_round_sequencer #(.NUM_ROUNDS(4), .SCORE_W(4), .VERIFY_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .access_ok(access_v[0]), .start_btn(start_v[0]),
    .p2_btn(p2_v[0]), .timer_done(tdone_v[0]), .verify_ok(vok_v[0]),
    .load_rand(a_load_rand), .load_p2(a_load_p2), .timer_run(a_timer_run),
    .round_num(a_round), .score(a_score), .busy(a_busy), .game_over(a_game_over),
    .dbg_state(a_state)
  );

  game_round_sequencer #(.NUM_ROUNDS(5), .SCORE_W(2), .VERIFY_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .access_ok(access_v[1]), .start_btn(start_v[1]),
    .p2_btn(p2_v[1]), .timer_done(tdone_v[1]), .verify_ok(vok_v[1]),
    .load_rand(b_load_rand), .load_p2(b_load_p2), .timer_run(b_timer_run),
    .round_num(b_round), .score(b_score), .busy(b_busy), .game_over(b_game_over),
    .dbg_state(b_state)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int a_rand_cnt = 0, a_p2_cnt = 0, b_rand_cnt = 0, b_p2_cnt = 0;
  int model_score[2];
  int model_round[2];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [2:0] st(input int sel);
    return (sel == 0) ? a_state : b_state;
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int sel, input logic [2:0] s, input string name);
    int k;
    k = 0;
    while (st(sel) != s && k < 60) begin
      tick(1);
      k++;
    end
    if (st(sel) != s) check(name, {5'd0, st(sel)}, {5'd0, s});
  endtask

  task automatic start_game(input int sel);
    start_v[sel] = 1'b1;
    tick(1);
    start_v[sel] = 1'b0;
    model_score[sel] = 0;
    model_round[sel] = 1;
  endtask

  task automatic push_round(input int sel, input int kind);
    int smax;
    logic [3:0] r, s;
    smax = (sel == 0) ? 15 : 3;
    if ((kind == K_OK || kind == K_SIM) && model_score[sel] < smax) model_score[sel]++;
`ifdef SEQ_TIMEOUT_PENALTY_EN
    if (kind == K_TO && model_score[sel] > 0) model_score[sel]--;
`endif
    r = 4'(model_round[sel]);
    s = 4'(model_score[sel]);
    if (sel == 0) exp_q0.push_back({r, s});
    else          exp_q1.push_back({r, s});
    model_round[sel]++;
  endtask

  task automatic play_round(input int sel, input int kind);
    wait_state(sel, S_RUN, "reach_run");
    push_round(sel, kind);
    vok_v[sel] = (kind == K_OK || kind == K_SIM);
    case (kind)
      K_OK, K_FAIL: begin
        tick(4);
        p2_v[sel] = 1'b1;
        tick(1);
        p2_v[sel] = 1'b0;
      end
      K_TO: begin
        tick(2);
        tdone_v[sel] = 1'b1;
        tick(1);
        tdone_v[sel] = 1'b0;
      end
      default: begin
        p2_v[sel] = 1'b1;
        tdone_v[sel] = 1'b1;
        tick(1);
        p2_v[sel] = 1'b0;
        tdone_v[sel] = 1'b0;
      end
    endcase
    wait_state(sel, S_SCORE, "reach_score");
    tick(1);
  endtask

  // monitor: counts strobes and checks {round, score} after every SCORE state
  initial begin
    logic pa, pb;
    logic [3:0] ra, rb;
    logic [7:0] e;
    pa = 1'b0;
    pb = 1'b0;
    ra = 4'd0;
    rb = 4'd0;
    forever begin
      @(negedge clk);
      if (a_load_rand) a_rand_cnt++;
      if (a_load_p2)   a_p2_cnt++;
      if (b_load_rand) b_rand_cnt++;
      if (b_load_p2)   b_p2_cnt++;
      if (pa) begin
        if (exp_q0.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL a_unexpected_round: got round %0d score %0d expected none", ra, a_score);
        end else begin
          e = exp_q0.pop_front();
          check("a_round_tag", {4'd0, ra}, {4'd0, e[7:4]});
          check("a_round_score", {4'd0, a_score}, {4'd0, e[3:0]});
        end
      end
      if (pb) begin
        if (exp_q1.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL b_unexpected_round: got round %0d score %0d expected none", rb, b_score);
        end else begin
          e = exp_q1.pop_front();
          check("b_round_tag", {4'd0, rb}, {4'd0, e[7:4]});
          check("b_round_score", {6'd0, b_score}, {4'd0, e[3:0]});
        end
      end
      pa = (a_state == S_SCORE);
      ra = a_round;
      pb = (b_state == S_SCORE);
      rb = b_round;
    end
  end

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    int base_r, base_p, mixed_final;
`ifdef SEQ_TIMEOUT_PENALTY_EN
    mixed_final = 1;
`else
    mixed_final = 2;
`endif
    for (int i = 0; i < 2; i++) begin
      access_v[i] = 1'b0; start_v[i] = 1'b0; p2_v[i] = 1'b0;
      tdone_v[i] = 1'b0; vok_v[i] = 1'b0;
      model_score[i] = 0; model_round[i] = 0;
    end
    rst = 1'b0;
    tick(3);
    check("rst_state", {5'd0, a_state}, {5'd0, S_IDLE});
    check("rst_round", {4'd0, a_round}, 8'd0);
    check("rst_score", {4'd0, a_score}, 8'd0);
    check("rst_load_rand", {7'd0, a_load_rand}, 8'd0);
    check("rst_load_p2", {7'd0, a_load_p2}, 8'd0);
    check("rst_timer_run", {7'd0, a_timer_run}, 8'd0);
    check("rst_busy", {7'd0, a_busy}, 8'd0);
    check("rst_game_over", {7'd0, a_game_over}, 8'd0);
    rst = 1'b1;
    tick(2);

    // full game, all rounds correct
    access_v[0] = 1'b1;
    base_r = a_rand_cnt;
    base_p = a_p2_cnt;
    start_game(0);
    check("start_arm", {5'd0, a_state}, {5'd0, S_ARM});
    check("start_load_rand", {7'd0, a_load_rand}, 8'd1);
    check("start_round", {4'd0, a_round}, 8'd1);
    check("start_busy", {7'd0, a_busy}, 8'd1);
    tick(1);
    check("run_timer_run", {7'd0, a_timer_run}, 8'd1);
    check("run_load_rand_low", {7'd0, a_load_rand}, 8'd0);
    for (int i = 0; i < 4; i++) play_round(0, K_OK);
    check("g1_load_rand_cnt", 8'(a_rand_cnt - base_r), 8'd4);
    check("g1_load_p2_cnt", 8'(a_p2_cnt - base_p), 8'd4);
    check("g1_score", {4'd0, a_score}, 8'd4);
    check("g1_round", {4'd0, a_round}, 8'd4);
    check("g1_game_over", {7'd0, a_game_over}, 8'd1);
    check("g1_busy", {7'd0, a_busy}, 8'd0);
    tick(3);
    check("done_hold_state", {5'd0, a_state}, {5'd0, S_DONE});
    check("done_hold_score", {4'd0, a_score}, 8'd4);

    // mixed results: ok, fail, timeout, ok
    start_game(0);
    check("restart_score_clear", {4'd0, a_score}, 8'd0);
    check("restart_round", {4'd0, a_round}, 8'd1);
    play_round(0, K_OK);
    play_round(0, K_FAIL);
    play_round(0, K_TO);
    play_round(0, K_OK);
    check("mixed_final_score", {4'd0, a_score}, 8'(mixed_final));

    // simultaneous p2_btn/timer_done, then abort in WAIT_V of round 2
    start_game(0);
    base_p = a_p2_cnt;
    play_round(0, K_SIM);
    check("sim_load_p2", 8'(a_p2_cnt - base_p), 8'd1);
    wait_state(0, S_RUN, "reach_run2");
    vok_v[0] = 1'b1;
    tick(4);
    p2_v[0] = 1'b1;
    tick(1);
    p2_v[0] = 1'b0;
    wait_state(0, S_WAIT_V, "reach_wait_v");
    access_v[0] = 1'b0;
    tick(1);
    check("abort_state", {5'd0, a_state}, {5'd0, S_IDLE});
    check("abort_timer_run", {7'd0, a_timer_run}, 8'd0);
    check("abort_round", {4'd0, a_round}, 8'd0);
    check("abort_score", {4'd0, a_score}, 8'd1);
    check("abort_busy", {7'd0, a_busy}, 8'd0);
    base_p = a_p2_cnt;
    base_r = a_rand_cnt;
    p2_v[0] = 1'b1;
    tick(1);
    p2_v[0] = 1'b0;
    start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    tick(3);
    check("idle_p2_ignored", 8'(a_p2_cnt - base_p), 8'd0);
    check("noaccess_start_state", {5'd0, a_state}, {5'd0, S_IDLE});
    check("noaccess_load_rand", 8'(a_rand_cnt - base_r), 8'd0);
    check("noaccess_round", {4'd0, a_round}, 8'd0);

    // asynchronous reset in the middle of a RUN cycle
    access_v[0] = 1'b1;
    start_game(0);
    play_round(0, K_OK);
    wait_state(0, S_RUN, "reach_run_rst");
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", {5'd0, a_state}, {5'd0, S_IDLE});
    check("arst_timer_run", {7'd0, a_timer_run}, 8'd0);
    check("arst_round", {4'd0, a_round}, 8'd0);
    check("arst_score", {4'd0, a_score}, 8'd0);
    check("arst_busy", {7'd0, a_busy}, 8'd0);
    check("arst_load_rand", {7'd0, a_load_rand}, 8'd0);
    tick(2);
    rst = 1'b1;
    tick(3);
    check("post_rst_idle", {5'd0, a_state}, {5'd0, S_IDLE});
    check("post_rst_busy", {7'd0, a_busy}, 8'd0);
    start_game(0);
    check("post_rst_start", {5'd0, a_state}, {5'd0, S_ARM});
    check("post_rst_load_rand", {7'd0, a_load_rand}, 8'd1);
    access_v[0] = 1'b0;
    tick(2);

    // saturation on the narrow-score instance
    access_v[1] = 1'b1;
    base_r = b_rand_cnt;
    start_game(1);
    for (int i = 0; i < 5; i++) play_round(1, K_OK);
    check("sat_score", {6'd0, b_score}, 8'd3);
    check("sat_round", {4'd0, b_round}, 8'd5);
    check("sat_game_over", {7'd0, b_game_over}, 8'd1);
    check("sat_load_rand_cnt", 8'(b_rand_cnt - base_r), 8'd5);

    tick(4);
    check("q0_drained", 8'(exp_q0.size()), 8'd0);
    check("q1_drained", 8'(exp_q1.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
